fir_mac_sequencer: RTL and testbench

//  Control sequencer for a time-multiplexed FIR datapath: one shared MAC, one sample delay-line RAM, one coef ROM.

---
 rtl/fir_mac_sequencer.sv | 118 +++++++++++
 tb/tb_fir_mac_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: FIR control sequencer that zeroes the delay line, writes each strobed sample, then steps N_TAPS MAC cycles. Defining FIR_OVR_COUNT_EN adds a saturating dropped-edge counter on port ovr_count.
module fir_mac_sequencer #(
  parameter int N_TAPS = 16,
  parameter int MAC_LAT = 2,
  localparam int ADDR_W = $clog2(N_TAPS)
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              input_ready,
  input  logic              ovr_clr,
  output logic              wr_en,
  output logic              wr_zero,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_load,
  output logic              output_ready,
  output logic              busy,
`ifdef FIR_OVR_COUNT_EN
  output logic [7:0]        ovr_count,
`endif
  output logic              overrun
);
  typedef enum logic [2:0] {INIT, IDLE, WRITE, MAC, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
  localparam logic [7:0] LAT_LAST = 8'(MAC_LAT - 1);
  state_t st, st_n;
  logic [ADDR_W-1:0] head, head_n, wr_addr_n, rd_addr_n, coef_addr_n;
  logic [7:0] lat, lat_n;
  logic in_q, strobe, drop;
  logic wr_en_n, wr_zero_n, mac_clr_n, mac_en_n, out_load_n, output_ready_n, busy_n, overrun_n;
  assign strobe = input_ready & ~in_q;
  assign drop = strobe & (st != IDLE);
  // Next state; st always names the phase currently visible on the registered outputs
  always_comb begin
    st_n = st;
    head_n = head;
    lat_n = lat;
    case (st)
      INIT: st_n = (wr_en && wr_addr == LAST) ? IDLE : INIT;
      IDLE: if (strobe) begin
        st_n = WRITE;
        head_n = (head == LAST) ? '0 : head + 1'b1;
      end
      WRITE: st_n = MAC;
      MAC: if (coef_addr == LAST) begin
        st_n = (MAC_LAT == 0) ? DONE : FLUSH;
        lat_n = '0;
      end
      FLUSH: begin
        st_n = (lat == LAT_LAST) ? DONE : FLUSH;
        lat_n = lat + 1'b1;
      end
      DONE: st_n = IDLE;
      default: st_n = INIT;
    endcase
  end
  // Output values for the next cycle, decoded from the next state; the address registers double as tap counters
  always_comb begin
    wr_en_n = st_n == INIT || st_n == WRITE;
    wr_zero_n = st_n == INIT;
    wr_addr_n = (st_n == INIT) ? (wr_en ? wr_addr + 1'b1 : '0) : (st_n == WRITE) ? head : '0;
    mac_en_n = st_n == MAC;
    mac_clr_n = st_n == MAC && st == WRITE;
    coef_addr_n = (st_n != MAC || st == WRITE) ? '0 : coef_addr + 1'b1;
    rd_addr_n = (st_n != MAC) ? '0 : (st == WRITE) ? wr_addr : (rd_addr == '0) ? LAST : rd_addr - 1'b1;
    out_load_n = st_n == DONE;
    output_ready_n = st == DONE;
    busy_n = st_n != IDLE;
    overrun_n = drop | (overrun & ~ovr_clr);
  end
  // State, head pointer, flush counter, strobe history and all output registers
  always_ff @(posedge ck) begin
    if (rst) begin
      st <= INIT;
      head <= '0;
      lat <= '0;
      in_q <= 1'b0;
      wr_en <= 1'b0;
      wr_zero <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      coef_addr <= '0;
      mac_clr <= 1'b0;
      mac_en <= 1'b0;
      out_load <= 1'b0;
      output_ready <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      head <= head_n;
      lat <= lat_n;
      in_q <= input_ready;
      wr_en <= wr_en_n;
      wr_zero <= wr_zero_n;
      wr_addr <= wr_addr_n;
      rd_addr <= rd_addr_n;
      coef_addr <= coef_addr_n;
      mac_clr <= mac_clr_n;
      mac_en <= mac_en_n;
      out_load <= out_load_n;
      output_ready <= output_ready_n;
      busy <= busy_n;
      overrun <= overrun_n;
    end
  end
`ifdef FIR_OVR_COUNT_EN
  // Dropped-edge count; a clear coinciding with a drop leaves a count of one
  always_ff @(posedge ck) begin
    if (rst) ovr_count <= '0;
    else if (ovr_clr) ovr_count <= {7'd0, drop};
    else if (drop && ovr_count != 8'hff) ovr_count <= ovr_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed bench for fir_mac_sequencer at N_TAPS=16, MAC_LAT=2
module tb_fir_mac_sequencer;
  logic ck = 1'b0;
  logic rst = 1'b1;
  logic input_ready = 1'b0;
  logic ovr_clr = 1'b0;
  logic wr_en, wr_zero, mac_clr, mac_en, out_load, output_ready, busy, overrun;
  logic [3:0] wr_addr, rd_addr, coef_addr;
`ifdef FIR_OVR_COUNT_EN
  logic [7:0] ovr_count;
`endif
  int errors = 0;
  int checks = 0;
  int exp_head = 0;
  always #5 ck = ~ck;
  fir_mac_sequencer dut (
    .ck(ck),
    .rst(rst),
    .input_ready(input_ready),
    .ovr_clr(ovr_clr),
    .wr_en(wr_en),
    .wr_zero(wr_zero),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .coef_addr(coef_addr),
    .mac_clr(mac_clr),
    .mac_en(mac_en),
    .out_load(out_load),
    .output_ready(output_ready),
    .busy(busy),
`ifdef FIR_OVR_COUNT_EN
    .ovr_count(ovr_count),
`endif
    .overrun(overrun)
  );
  task automatic tick();
    @(negedge ck);
  endtask
  task automatic check_init(input string tag);
    checks++;
    if ({wr_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_first_cycle got wr_en,busy=%b exp 00", tag, {wr_en, busy});
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({wr_en, wr_zero, wr_addr, busy, output_ready} !== {1'b1, 1'b1, 4'(i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s_zero_write%0d got en,zero,addr,busy,rdy=%b exp %b", tag, i,
                 {wr_en, wr_zero, wr_addr, busy, output_ready}, {1'b1, 1'b1, 4'(i), 1'b1, 1'b0});
      end
    end
    tick();
    checks++;
    if ({wr_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_idle got wr_en,busy=%b exp 00", tag, {wr_en, busy});
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({wr_en, wr_zero, wr_addr, rd_addr, coef_addr, mac_clr, mac_en, out_load, output_ready, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp all zero",
               {wr_en, wr_zero, wr_addr, rd_addr, coef_addr, mac_clr, mac_en, out_load, output_ready, busy, overrun});
    end
    rst = 1'b0;
    check_init("reset");
    exp_head = 0;
  endtask
  task automatic test_single();
    int h;
    logic [3:0] rd;
    h = exp_head;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    checks++;
    if ({wr_en, wr_zero, wr_addr, mac_en, busy} !== {1'b1, 1'b0, 4'(h), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_write got en,zero,addr,mac,busy=%b exp %b", {wr_en, wr_zero, wr_addr, mac_en, busy},
               {1'b1, 1'b0, 4'(h), 1'b0, 1'b1});
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      rd = 4'((h - k + 16) % 16);
      checks++;
      if ({mac_en, mac_clr, coef_addr, rd_addr, wr_en} !== {1'b1, k == 0, 4'(k), rd, 1'b0}) begin
        errors++;
        $display("FAIL single_tap%0d got en,clr,coef,rd,wr=%b exp %b", k, {mac_en, mac_clr, coef_addr, rd_addr, wr_en},
                 {1'b1, k == 0, 4'(k), rd, 1'b0});
      end
    end
    for (int c = 18; c <= 22; c++) begin
      logic [3:0] ex;
      tick();
      ex = (c == 20) ? 4'b0101 : (c == 21) ? 4'b0010 : (c == 22) ? 4'b0000 : 4'b0001;
      checks++;
      if ({mac_en, out_load, output_ready, busy} !== ex) begin
        errors++;
        $display("FAIL single_E+%0d got mac,load,rdy,busy=%b exp %b", c, {mac_en, out_load, output_ready, busy}, ex);
      end
    end
    exp_head = (h + 1) % 16;
  endtask
  task automatic test_wrap();
    int pulses = 0;
    int writes = 0;
    logic ovr = 1'b0;
    for (int s = 0; s < 20; s++) begin
      input_ready = 1'b1;
      tick();
      input_ready = 1'b0;
      checks++;
      if ({wr_en, wr_addr} !== {1'b1, 4'(exp_head)}) begin
        errors++;
        $display("FAIL wrap_write%0d got en,addr=%b exp %b", s, {wr_en, wr_addr}, {1'b1, 4'(exp_head)});
      end
      exp_head = (exp_head + 1) % 16;
      for (int c = 0; c < 24; c++) begin
        tick();
        if (output_ready) pulses++;
        if (wr_en) writes++;
        ovr = ovr | overrun;
      end
    end
    checks++;
    if (pulses != 20 || writes != 0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL wrap_totals got pulses=%0d extra_writes=%0d overrun=%b exp 20 0 0", pulses, writes, ovr);
    end
  endtask
  task automatic test_overrun();
    int pulses = 0;
    int writes = 0;
    int h;
    h = exp_head;
    for (int s = 0; s < 30; s++) begin
      input_ready = (s == 0 || s == 10 || s == 14);
      ovr_clr = (s == 14);
      tick();
      if (output_ready) pulses++;
      if (wr_en) writes++;
      if (s == 0) begin
        checks++;
        if ({wr_en, wr_addr} !== {1'b1, 4'(h)}) begin
          errors++;
          $display("FAIL ovr_write got en,addr=%b exp %b", {wr_en, wr_addr}, {1'b1, 4'(h)});
        end
      end
      if (s == 10 || s == 14) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL ovr_flag_step%0d got %b exp 1", s, overrun);
        end
`ifdef FIR_OVR_COUNT_EN
        checks++;
        if (ovr_count !== 8'd1) begin
          errors++;
          $display("FAIL ovr_count_step%0d got %0d exp 1", s, ovr_count);
        end
`endif
      end
    end
    input_ready = 1'b0;
    ovr_clr = 1'b0;
    checks++;
    if (writes != 1 || pulses != 1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_totals got writes=%0d pulses=%0d overrun=%b exp 1 1 1", writes, pulses, overrun);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
`ifdef FIR_OVR_COUNT_EN
    checks++;
    if (ovr_count !== 8'd0) begin
      errors++;
      $display("FAIL ovr_count_clear got %0d exp 0", ovr_count);
    end
`endif
    exp_head = (h + 1) % 16;
  endtask
  task automatic test_hold();
    int pulses = 0;
    int writes = 0;
    logic [3:0] addr = 4'hx;
    for (int s = 0; s < 85; s++) begin
      input_ready = (s < 60);
      tick();
      if (output_ready) pulses++;
      if (wr_en) begin
        writes++;
        addr = wr_addr;
      end
    end
    checks++;
    if (writes != 1 || pulses != 1 || overrun !== 1'b0 || addr !== 4'(exp_head)) begin
      errors++;
      $display("FAIL hold_one_sample got writes=%0d pulses=%0d overrun=%b addr=%0d exp 1 1 0 %0d", writes, pulses,
               overrun, addr, exp_head);
    end
    exp_head = (exp_head + 1) % 16;
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    int h;
    h = exp_head;
    for (int s = 0; s < 48; s++) begin
      input_ready = (s == 0 || s == 21);
      tick();
      if (output_ready) pulses++;
      if (s == 20) begin
        checks++;
        if ({output_ready, busy} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_ready_cycle got rdy,busy=%b exp 10", {output_ready, busy});
        end
      end
      if (s == 21) begin
        checks++;
        if ({wr_en, wr_addr} !== {1'b1, 4'((h + 1) % 16)}) begin
          errors++;
          $display("FAIL b2b_second_write got en,addr=%b exp %b", {wr_en, wr_addr}, {1'b1, 4'((h + 1) % 16)});
        end
      end
    end
    input_ready = 1'b0;
    checks++;
    if (pulses != 2 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_totals got pulses=%0d overrun=%b exp 2 0", pulses, overrun);
    end
    exp_head = (h + 2) % 16;
  endtask
  task automatic test_rst_mid();
    int pulses = 0;
    for (int s = 0; s < 8; s++) begin
      input_ready = (s == 0 || s == 4);
      tick();
    end
    input_ready = 1'b0;
    checks++;
    if ({mac_en, overrun} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre got mac_en,overrun=%b exp 11", {mac_en, overrun});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({wr_en, mac_en, out_load, output_ready, busy, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_cleared got %b exp 000000", {wr_en, mac_en, out_load, output_ready, busy, overrun});
    end
`ifdef FIR_OVR_COUNT_EN
    checks++;
    if (ovr_count !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_ovr_count got %0d exp 0", ovr_count);
    end
`endif
    rst = 1'b0;
    check_init("rstmid");
    exp_head = 0;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    checks++;
    if ({wr_en, wr_zero, wr_addr} !== 6'b100000) begin
      errors++;
      $display("FAIL rstmid_first_write got en,zero,addr=%b exp 100000", {wr_en, wr_zero, wr_addr});
    end
    for (int s = 0; s < 25; s++) begin
      tick();
      if (output_ready) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL rstmid_after got pulses=%0d exp 1", pulses);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overrun();
    test_hold();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
